// File: rtl/data_memory_param_if.sv
// ---------------------------------------------------------------------------
// data_memory_param_if
//
// Request/response bundle between the control unit (master) and the
// parametrised data memory (slave). clk and reset are not part of the bundle.
//
// Signals:
//   write_enable  master->slave  write request
//   read_enable   master->slave  read request
//   address       master->slave  word address (ADDR_W bits)
//   data_in       master->slave  write data (DATA_W bits)
//   data_out      slave->master  registered read data
//   read_valid    slave->master  one-cycle pulse, data_out updated by a read
//   busy          slave->master  reset / init sweep in progress
//   write_error   slave->master  one-cycle pulse, protected-word write rejected
// ---------------------------------------------------------------------------
interface data_memory_param_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 4
) ();

  logic              write_enable;
  logic              read_enable;
  logic [ADDR_W-1:0] address;
  logic [DATA_W-1:0] data_in;
  logic [DATA_W-1:0] data_out;
  logic              read_valid;
  logic              busy;
  logic              write_error;

  modport master (
    output write_enable, read_enable, address, data_in,
    input  data_out, read_valid, busy, write_error
  );

  modport slave (
    input  write_enable, read_enable, address, data_in,
    output data_out, read_valid, busy, write_error
  );

endinterface

// File: rtl/data_memory_param.sv
// ---------------------------------------------------------------------------
// data_memory_param
//
// Single-port synchronous data memory of 2^ADDR_W words of DATA_W bits.
// After reset a sweep writes every word (INIT_VALUE, or PROT_VALUE at the
// protected address) while busy is high. In READY, writes take one edge,
// reads return registered data one edge later with a read_valid pulse, and
// writes to the protected word are rejected with a write_error pulse.
//
// Ports:
//   clk    system clock, all state changes on the rising edge
//   reset  synchronous, active-high reset
//   bus    data_memory_param_if slave modport (requests in, data/status out)
// ---------------------------------------------------------------------------
module data_memory_param #(
  parameter int                DATA_W        = 8,
  parameter int                ADDR_W        = 4,
  parameter logic [DATA_W-1:0] INIT_VALUE    = '0,
  parameter bit                PROT_EN       = 1'b1,
  parameter int                PROT_ADDR     = 2,
  parameter logic [DATA_W-1:0] PROT_VALUE    = DATA_W'(8'b00101110),
  parameter bit                WRITE_THROUGH = 1'b0
) (
  input  logic                clk,
  input  logic                reset,
  data_memory_param_if.slave  bus
);

  localparam int                DEPTH  = 1 << ADDR_W;
  localparam logic [ADDR_W-1:0] PROT_A = ADDR_W'(PROT_ADDR);

  typedef enum logic {
    ST_INIT,
    ST_READY
  } state_t;

  state_t            state;
  // One bit wider than the address: the carry into the MSB marks the end of
  // the sweep without the counter wrapping back onto address 0.
  logic [ADDR_W:0]   sweep_cnt;
  logic [ADDR_W:0]   sweep_next;
  logic [ADDR_W-1:0] sweep_addr;

  logic [DATA_W-1:0] mem [DEPTH];

  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;

  logic              is_prot;
  logic              wr_accept;

  logic [DATA_W-1:0] data_out_q;
  logic              read_valid_q;
  logic              busy_q;
  logic              write_error_q;

  assign sweep_next = sweep_cnt + 1'b1;
  assign sweep_addr = sweep_cnt[ADDR_W-1:0];

  assign is_prot   = PROT_EN && (bus.address == PROT_A);
  assign wr_accept = (state == ST_READY) && bus.write_enable && !is_prot;

  // Single write port shared by the init sweep and normal writes.
  // NOTE: every output of this block gets a default first so no path leaves
  // a value unassigned, which would otherwise infer a latch.
  always_comb begin
    mem_we    = 1'b0;
    mem_addr  = bus.address;
    mem_wdata = bus.data_in;
    if (!reset) begin
      if (state == ST_INIT) begin
        mem_we    = 1'b1;
        mem_addr  = sweep_addr;
        mem_wdata = (PROT_EN && (sweep_addr == PROT_A)) ? PROT_VALUE : INIT_VALUE;
      end else if (wr_accept) begin
        mem_we = 1'b1;
      end
    end
  end

  // NOTE: the storage array has no reset branch; its contents are defined by
  // the init sweep, and a reset term would turn the array into a flop bank.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[mem_addr] <= mem_wdata;
    end
  end

  // Control FSM with registered outputs.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= ST_INIT;
      sweep_cnt     <= '0;
      busy_q        <= 1'b1;
      data_out_q    <= '0;
      read_valid_q  <= 1'b0;
      write_error_q <= 1'b0;
    end else begin
      // Both strobes are single-cycle unless re-armed below.
      read_valid_q  <= 1'b0;
      write_error_q <= 1'b0;
      case (state)
        ST_INIT: begin
          busy_q    <= 1'b1;
          sweep_cnt <= sweep_next;
          if (sweep_next[ADDR_W]) begin
            state  <= ST_READY;
            busy_q <= 1'b0;
          end
        end
        ST_READY: begin
          busy_q <= 1'b0;
          if (bus.write_enable) begin
            if (is_prot) begin
              write_error_q <= 1'b1;
            end
            // Simultaneous read: forward the write data, or the constant
            // when the write was rejected, since that is what the word holds.
            if (bus.read_enable && WRITE_THROUGH) begin
              data_out_q   <= is_prot ? PROT_VALUE : bus.data_in;
              read_valid_q <= 1'b1;
            end
          end else if (bus.read_enable) begin
            data_out_q   <= mem[bus.address];
            read_valid_q <= 1'b1;
          end
        end
        default: begin
          state     <= ST_INIT;
          sweep_cnt <= '0;
          busy_q    <= 1'b1;
        end
      endcase
    end
  end

  assign bus.data_out    = data_out_q;
  assign bus.read_valid  = read_valid_q;
  assign bus.busy        = busy_q;
  assign bus.write_error = write_error_q;

endmodule
